layer_seq_fsm: RTL and testbench
================================

Name: layer_seq_fsm

Overview:
- Parametrised sequencer for the N-layer MLP inference datapath. It is the successor to the fixed two-layer control FSM.
- Runs: MAC clear, then image load, then per layer bias-init / setup / MAC sweep / activation, then argmax.
- Layer count and per-layer input lengths come from parameters. It adds a MAC-phase stall, abort, a done/ack handshake and a performance counter.
- Sits between the top-level start/done interface and the memory controller plus MAC arrays.

Parameters:
- NUM_LAYERS, 2, number of layers (1..4).
- IDX_W, 10, width of row_idx and of each IN_SIZES field.
- IN_SIZES, {10'd32,10'd784}, packed input length per layer; layer 0 is in the LSBs. Each field is 1..2^IDX_W-1.
- SETUP_CYC, 2, idle cycles between bias init and the first MAC enable (0..15). 0 means the SETUP state is skipped.
- ACT_CYC, 1..15, default 2: activation-phase length.
- PERF_W, 20, width of the performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request an inference; sampled in IDLE, or in DONE together with done_ack
- abort  in  1  cancel the current inference
- stall  in  1  freeze the MAC sweep (memory not ready)
- done_ack  in  1  consumer acknowledges done
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high throughout DONE
- aborted  out  1  one-cycle pulse, the cycle after an abort is accepted
- layer_idx  out  max(1,$clog2(NUM_LAYERS))  current layer; 0 outside layer phases
- row_idx  out  IDX_W  current input index during MAC; 0 otherwise
- mac_clr  out  NUM_LAYERS  clear all accumulators (INIT only)
- bias_init  out  NUM_LAYERS  one-hot, BIAS state of layer l
- mac_en  out  NUM_LAYERS  one-hot, MAC state of layer l and not stalled
- act_en  out  NUM_LAYERS  one-hot, first ACT cycle of layer l
- load_img  out  1  first LOAD cycle
- find_max  out  1  first ARGMAX cycle
- perf_cycles  out  PERF_W  cycles spent from INIT through the last ARGMAX cycle

Behaviour:
- Output timing: all outputs are decoded from the registered state, layer counter and cycle counter (Moore). They are valid in the cycle the state is occupied.
- Reset: state IDLE. All outputs are 0; perf_cycles is 0.
- States: IDLE, INIT, LOAD, BIAS, SETUP, MAC, ACT, ARGMAX, DONE.
- IDLE:
  - Goes to INIT when start=1.
  - All other inputs are ignored.
- INIT:
  - Lasts 1 cycle.
  - mac_clr is all ones and perf_cycles is cleared to 1.
  - Goes to LOAD.
- LOAD:
  - Lasts 2 cycles; load_img=1 in the first cycle only.
  - Goes to BIAS with layer l=0.
- BIAS:
  - Lasts 1 cycle with bias_init[l]=1.
  - Goes to SETUP, or to MAC directly if SETUP_CYC=0.
- SETUP:
  - Lasts SETUP_CYC cycles with no enables.
- MAC:
  - Runs N=IN_SIZES[l] active cycles. In active cycle k, mac_en[l]=1 and row_idx=k, for k=0..N-1.
  - While stall=1: mac_en=0, row_idx and the cycle counter hold, and the state is extended one cycle per stalled cycle.
  - After active cycle N-1: if l<NUM_LAYERS-1, go to ACT; otherwise go to ARGMAX.
- ACT:
  - Lasts ACT_CYC cycles; act_en[l]=1 in the first cycle.
  - Then l increments and the FSM goes to BIAS.
  - The last layer has no ACT.
- ARGMAX:
  - Lasts 2 cycles; find_max=1 in the first.
  - Goes to DONE.
- DONE:
  - done=1 and perf_cycles holds.
  - If done_ack=0: stay. If done_ack=1 and start=0: go to IDLE. If done_ack=1 and start=1: go to INIT (back-to-back run).
- perf_cycles:
  - Increments every cycle in the states INIT..ARGMAX, including stalled cycles.
  - Saturates at all ones.
- stall is ignored outside MAC.
- abort:
  - In any busy state, the next state is IDLE and aborted=1 in that IDLE cycle.
  - All enables are 0 from that cycle on and perf_cycles keeps its last value.
  - abort has priority over stall and over state completion.
  - abort is ignored in IDLE and DONE.
- rst has priority over everything, including mid-MAC; state returns to IDLE and all outputs go to 0.
- start while busy is ignored and is not queued.
- Latency for default parameters, start at cycle t:
  - INIT at t+1, done=1 at t+830, perf_cycles=829.
  - Breakdown: 1+2 + (1+2+784+2) + (1+2+32) + 2.

Test Plan:
- Default run:
  - Stimulus: pulse start at cycle t.
  - Response: load_img at t+2. bias_init[0] at t+4. mac_en[0] for t+7..t+790 with row_idx 0..783. act_en[0] at t+791. bias_init[1] at t+793. mac_en[1] with rows 0..31 at t+796..t+827. find_max at t+828. done at t+830, perf_cycles=829.
- Stall:
  - Stimulus: stall=1 for 3 cycles while row_idx=100 in layer 0.
  - Response: mac_en=0 and row_idx=100 held for those 3 cycles. done at t+833, perf_cycles=832. stall asserted during SETUP has no effect.
- Abort:
  - Stimulus: abort at layer-0 row 400.
  - Response: next cycle is IDLE with aborted=1 for one cycle, busy=0, mac_en=0. A new start then gives a full nominal run with perf_cycles=829.
- Handshake:
  - Stimulus: hold done_ack=0 for 50 cycles, then assert done_ack together with start.
  - Response: done stays 1 for the whole wait. The next cycle is INIT with mac_clr all ones and no IDLE cycle in between. A start pulse while busy changes nothing.
- Reconfiguration:
  - Stimulus: NUM_LAYERS=3, IN_SIZES={10,16,8}, SETUP_CYC=0, ACT_CYC=2.
  - Response: mac_en[0] runs rows 0..7, mac_en[1] rows 0..15, mac_en[2] rows 0..9. act_en[2] is never asserted. perf_cycles=46.
- Reset mid-run:
  - Stimulus: rst=1 during layer-1 MAC.
  - Response: the next cycle has all outputs 0, perf_cycles=0, state IDLE.

Source files
------------

// File: rtl/layer_seq_if.sv
// Control bundle between the layer sequencer and its surroundings: start/abort/stall/ack in,
// phase strobes, indices and the cycle counter out.
interface layer_seq_if #(
  parameter int NUM_LAYERS = 2,
  parameter int IDX_W      = 10,
  parameter int PERF_W     = 20
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                  start;
  logic                  abort;
  logic                  stall;
  logic                  done_ack;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic [LW-1:0]         layer_idx;
  logic [IDX_W-1:0]      row_idx;
  logic [NUM_LAYERS-1:0] mac_clr;
  logic [NUM_LAYERS-1:0] bias_init;
  logic [NUM_LAYERS-1:0] mac_en;
  logic [NUM_LAYERS-1:0] act_en;
  logic                  load_img;
  logic                  find_max;
  logic [PERF_W-1:0]     perf_cycles;

  modport master (
    input  start, abort, stall, done_ack,
    output busy, done, aborted, layer_idx, row_idx, mac_clr, bias_init,
           mac_en, act_en, load_img, find_max, perf_cycles
  );

  modport slave (
    output start, abort, stall, done_ack,
    input  busy, done, aborted, layer_idx, row_idx, mac_clr, bias_init,
           mac_en, act_en, load_img, find_max, perf_cycles
  );
endinterface

// File: rtl/layer_seq_fsm.sv
// Sequencer for the N-layer MLP datapath: clear, image load, per-layer bias/setup/MAC/activation,
// argmax, then a done/ack handshake. Outputs are registered from the next-state decode.
module layer_seq_fsm #(
  parameter int                          NUM_LAYERS = 2,
  parameter int                          IDX_W      = 10,
  parameter logic [NUM_LAYERS*IDX_W-1:0] IN_SIZES   = {10'd32, 10'd784},
  parameter int                          SETUP_CYC  = 2,
  parameter int                          ACT_CYC    = 2,
  parameter int                          PERF_W     = 20
) (
  input logic         clk,
  input logic         rst,
  layer_seq_if.master bus
);
  localparam int LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CW    = (IDX_W > 4) ? IDX_W : 4;
  localparam int NL_P2 = 1 << LW;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LOAD, S_BIAS, S_SETUP, S_MAC, S_ACT, S_ARGMAX, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         layer_q, layer_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PERF_W-1:0]     perf_q, perf_d;
  logic                  aborted_q, aborted_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  load_q, load_d, fmax_q, fmax_d;
  logic [NUM_LAYERS-1:0] clr_q, clr_d, bias_q, bias_d, mac_q, mac_d, act_q, act_d;
  logic [LW-1:0]         lidx_q, lidx_d;
  logic [IDX_W-1:0]      row_q, row_d;
  logic [NUM_LAYERS-1:0] oh;
  logic [IDX_W-1:0]      n_rows;
  logic                  in_busy;
  logic                  last_layer;

  // Padded to a power of two so the layer counter can index without a range check.
  logic [IDX_W-1:0] size_tbl [NL_P2];
  for (genvar g = 0; g < NL_P2; g++) begin : g_size
    if (g < NUM_LAYERS) begin : g_real
      assign size_tbl[g] = IN_SIZES[g*IDX_W +: IDX_W];
    end else begin : g_pad
      assign size_tbl[g] = IDX_W'(1);
    end
  end

  assign n_rows     = size_tbl[layer_q];
  assign last_layer = (layer_q == LW'(NUM_LAYERS - 1));
  assign in_busy    = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    cnt_d     = cnt_q;
    aborted_d = 1'b0;
    if (bus.abort && in_busy) begin
      state_d   = S_IDLE;
      layer_d   = '0;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) state_d = S_INIT;
        S_INIT: begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
        S_LOAD: begin
          if (cnt_q == CW'(1)) begin
            state_d = S_BIAS;
            layer_d = '0;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CW'(1);
        end
        S_BIAS: begin
          state_d = (SETUP_CYC == 0) ? S_MAC : S_SETUP;
          cnt_d   = '0;
        end
        S_SETUP: begin
          if (cnt_q == CW'(SETUP_CYC - 1)) begin
            state_d = S_MAC;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CW'(1);
        end
        S_MAC: begin
          if (!bus.stall) begin
            if (cnt_q == CW'(n_rows) - CW'(1)) begin
              state_d = last_layer ? S_ARGMAX : S_ACT;
              cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
          end
        end
        S_ACT: begin
          if (cnt_q == CW'(ACT_CYC - 1)) begin
            state_d = S_BIAS;
            layer_d = layer_q + LW'(1);
            cnt_d   = '0;
          end else cnt_d = cnt_q + CW'(1);
        end
        S_ARGMAX: begin
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CW'(1);
        end
        S_DONE: if (bus.done_ack) state_d = bus.start ? S_INIT : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    perf_d = perf_q;
    if (state_d == S_INIT) perf_d = PERF_W'(1);
    else if ((state_d != S_IDLE) && (state_d != S_DONE) && (perf_q != '1))
      perf_d = perf_q + PERF_W'(1);

    oh     = NUM_LAYERS'(1) << layer_d;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    clr_d  = (state_d == S_INIT) ? '1 : '0;
    load_d = (state_d == S_LOAD) && (cnt_d == '0);
    fmax_d = (state_d == S_ARGMAX) && (cnt_d == '0);
    bias_d = (state_d == S_BIAS) ? oh : '0;
    mac_d  = (state_d == S_MAC) ? oh : '0;
    act_d  = ((state_d == S_ACT) && (cnt_d == '0)) ? oh : '0;
    lidx_d = (state_d inside {S_BIAS, S_SETUP, S_MAC, S_ACT}) ? layer_d : '0;
    row_d  = (state_d == S_MAC) ? cnt_d[IDX_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      layer_q   <= '0;
      cnt_q     <= '0;
      perf_q    <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      fmax_q    <= 1'b0;
      clr_q     <= '0;
      bias_q    <= '0;
      mac_q     <= '0;
      act_q     <= '0;
      lidx_q    <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      cnt_q     <= cnt_d;
      perf_q    <= perf_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      load_q    <= load_d;
      fmax_q    <= fmax_d;
      clr_q     <= clr_d;
      bias_q    <= bias_d;
      mac_q     <= mac_d;
      act_q     <= act_d;
      lidx_q    <= lidx_d;
      row_q     <= row_d;
    end
  end

  // Stall gates the enable in the same cycle; the registered state only marks the MAC phase.
  assign bus.mac_en      = mac_q & {NUM_LAYERS{~bus.stall}};
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.layer_idx   = lidx_q;
  assign bus.row_idx     = row_q;
  assign bus.mac_clr     = clr_q;
  assign bus.bias_init   = bias_q;
  assign bus.act_en      = act_q;
  assign bus.load_img    = load_q;
  assign bus.find_max    = fmax_q;
  assign bus.perf_cycles = perf_q;
endmodule

// File: tb/tb_layer_seq_fsm.sv
// Scoreboard bench for layer_seq_fsm: a phase-level model lists the expected strobe events of
// each run with their cycle numbers; a negedge monitor turns DUT strobes into events and compares.
module tb_layer_seq_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_seq_if #(.NUM_LAYERS(2), .IDX_W(10), .PERF_W(20)) if0 ();
  layer_seq_if #(.NUM_LAYERS(3), .IDX_W(10), .PERF_W(20)) if1 ();

  layer_seq_fsm #(.NUM_LAYERS(2), .IDX_W(10), .IN_SIZES({10'd32, 10'd784}),
                  .SETUP_CYC(2), .ACT_CYC(2), .PERF_W(20))
    dut0 (.clk(clk), .rst(rst), .bus(if0));

  layer_seq_fsm #(.NUM_LAYERS(3), .IDX_W(10), .IN_SIZES({10'd10, 10'd16, 10'd8}),
                  .SETUP_CYC(0), .ACT_CYC(2), .PERF_W(20))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  localparam int K_CLR = 0, K_LOAD = 1, K_BIAS = 2, K_MAC = 3, K_ACT = 4,
                 K_FMAX = 5, K_DONE = 6, K_ABORT = 7;

  typedef struct packed {int kind; int layer; int row; int aux; int cyc;} ev_t;
  ev_t exp_q0[$];
  ev_t exp_q1[$];

  int cfg_nl[2];
  int cfg_sz[2][4];
  int cfg_setup[2];
  int cfg_act[2];
  bit stall_plan [0:16383];
  bit done_prev [2];

  always @(posedge clk) begin
    #1;
    if0.stall = (cyc < 16384) ? stall_plan[cyc] : 1'b0;
    if1.stall = if0.stall;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int inst, input int k, input int l, input int r, input int a,
                      input int c);
    ev_t e;
    e.kind = k; e.layer = l; e.row = r; e.aux = a; e.cyc = c;
    if (inst == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  // Phase walk: each phase is a fixed length except MAC, which skips planned stall cycles.
  task automatic model_run(input int inst, input int t, input int ab_l, input int ab_r,
                           output int fin, output bit abd);
    int c, nl, r;
    nl  = cfg_nl[inst];
    abd = 1'b0;
    c   = t + 1;
    push(inst, K_CLR, 0, (1 << nl) - 1, 0, c);
    c += 1;
    push(inst, K_LOAD, 0, 0, 1, c);
    c += 2;
    for (int l = 0; l < nl; l++) begin
      push(inst, K_BIAS, l, 0, l, c);
      c += 1 + cfg_setup[inst];
      r = 0;
      while (r < cfg_sz[inst][l]) begin
        if (!stall_plan[c]) begin
          push(inst, K_MAC, l, r, l, c);
          if (l == ab_l && r == ab_r) begin
            push(inst, K_ABORT, 0, 0, c - t, c + 1);
            fin = c + 1;
            abd = 1'b1;
            return;
          end
          r++;
        end
        c++;
      end
      if (l < nl - 1) begin
        push(inst, K_ACT, l, 0, l, c);
        c += cfg_act[inst];
      end
    end
    push(inst, K_FMAX, 0, 0, 1, c);
    c += 2;
    push(inst, K_DONE, 0, 0, c - t - 1, c);
    fin = c;
  endtask

  task automatic obs(input int inst, input int k, input int l, input int r, input int a);
    ev_t g, e;
    g.kind = k; g.layer = l; g.row = r; g.aux = a; g.cyc = cyc;
    checks++;
    if ((inst == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
      failures++;
      $display("FAIL ev_unexpected inst=%0d got(k=%0d l=%0d r=%0d a=%0d c=%0d) exp=none",
               inst, k, l, r, a, cyc);
    end else begin
      if (inst == 0) e = exp_q0.pop_front();
      else e = exp_q1.pop_front();
      if (g != e) begin
        failures++;
        $display("FAIL ev_cmp inst=%0d got(k=%0d l=%0d r=%0d a=%0d c=%0d) exp(k=%0d l=%0d r=%0d a=%0d c=%0d)",
                 inst, g.kind, g.layer, g.row, g.aux, g.cyc,
                 e.kind, e.layer, e.row, e.aux, e.cyc);
      end
    end
  endtask

  task automatic mon(input int inst, input logic [3:0] clr, input logic [3:0] bias,
                     input logic [3:0] mac, input logic [3:0] act, input logic load,
                     input logic fmax, input logic dn, input logic ab, input logic bsy,
                     input int lidx, input int row, input int perf);
    if (clr != 4'd0) obs(inst, K_CLR, 0, int'(clr), 0);
    if (load) obs(inst, K_LOAD, 0, 0, int'(bsy));
    for (int l = 0; l < 4; l++) begin
      if (bias[l]) obs(inst, K_BIAS, l, 0, lidx);
      if (mac[l]) obs(inst, K_MAC, l, row, lidx);
      if (act[l]) obs(inst, K_ACT, l, 0, lidx);
    end
    if (fmax) obs(inst, K_FMAX, 0, 0, int'(bsy));
    if (dn && !done_prev[inst]) obs(inst, K_DONE, 0, int'(bsy), perf);
    if (ab) obs(inst, K_ABORT, 0, int'({bsy, |mac}), perf);
  endtask

  always @(negedge clk) begin
    if (cyc >= 2) begin
      mon(0, 4'(if0.mac_clr), 4'(if0.bias_init), 4'(if0.mac_en), 4'(if0.act_en),
          if0.load_img, if0.find_max, if0.done, if0.aborted, if0.busy,
          int'(if0.layer_idx), int'(if0.row_idx), int'(if0.perf_cycles));
      mon(1, 4'(if1.mac_clr), 4'(if1.bias_init), 4'(if1.mac_en), 4'(if1.act_en),
          if1.load_img, if1.find_max, if1.done, if1.aborted, if1.busy,
          int'(if1.layer_idx), int'(if1.row_idx), int'(if1.perf_cycles));
    end
    done_prev[0] = if0.done;
    done_prev[1] = if1.done;
  end

  // Expected events at or before limit that never showed up are misses.
  task automatic drain(input int inst, input int limit);
    ev_t e;
    int  n;
    n = 0;
    checks++;
    while ((inst == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0)) begin
      if (inst == 0) e = exp_q0.pop_front();
      else e = exp_q1.pop_front();
      if (e.cyc <= limit) n++;
    end
    if (n != 0) begin
      failures++;
      $display("FAIL ev_missed inst=%0d missing=%0d exp=0", inst, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic gen_stall(input int from, input int mode);
    for (int c = from; c < from + 2500 && c < 16384; c++)
      stall_plan[c] = (mode == 1) ? ($urandom_range(0, 15) == 0) : 1'b0;
    if (mode == 2) begin
      stall_plan[from + 5] = 1'b1;
      stall_plan[from + 6] = 1'b1;
      for (int c = from + 107; c < from + 110; c++) stall_plan[c] = 1'b1;
    end
  endtask

  task automatic run(input int inst, input int ab_l, input int ab_r, input int mode,
                     output int t, output int fin);
    bit abd;
    t = cyc;
    gen_stall(t, mode);
    model_run(inst, t, ab_l, ab_r, fin, abd);
    if (inst == 0) if0.start = 1'b1; else if1.start = 1'b1;
    tick();
    if0.start = 1'b0;
    if1.start = 1'b0;
    if (abd) begin
      wait_until(fin - 1);
      if (inst == 0) if0.abort = 1'b1; else if1.abort = 1'b1;
      tick();
      if0.abort = 1'b0;
      if1.abort = 1'b0;
    end
  endtask

  initial begin
    int t, fin, r_cyc, al, ar;
    cfg_nl[0] = 2; cfg_sz[0] = '{784, 32, 0, 0}; cfg_setup[0] = 2; cfg_act[0] = 2;
    cfg_nl[1] = 3; cfg_sz[1] = '{8, 16, 10, 0};  cfg_setup[1] = 0; cfg_act[1] = 2;
    if0.start = 0; if0.abort = 0; if0.done_ack = 1;
    if1.start = 0; if1.abort = 0; if1.done_ack = 1;

    rst = 1'b1;
    repeat (4) tick();
    #2;
    chk("rst_busy", int'(if0.busy), 0);
    chk("rst_done", int'(if0.done), 0);
    chk("rst_perf", int'(if0.perf_cycles), 0);
    chk("rst_mac_clr", int'(if0.mac_clr), 0);
    chk("rst_mac_en", int'(if0.mac_en), 0);
    chk("rst_aborted", int'(if1.aborted), 0);
    chk("rst_busy1", int'(if1.busy), 0);
    rst = 1'b0;
    tick();

    // nominal default run
    run(0, -1, -1, 0, t, fin);
    wait_until(fin + 2);
    chk("default_perf", int'(if0.perf_cycles), 829);
    chk("default_idle_after_ack", int'(if0.busy), 0);
    drain(0, cyc);

    // stall during SETUP (ignored) and at layer-0 row 100
    run(0, -1, -1, 2, t, fin);
    wait_until(t + 107);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_row_hold", int'(if0.row_idx), 100);
      chk("stall_mac_en", int'(if0.mac_en), 0);
      tick();
    end
    wait_until(fin + 2);
    chk("stall_perf", int'(if0.perf_cycles), 832);
    drain(0, cyc);

    // abort at layer-0 row 400, abort ignored in IDLE, then full nominal and random-stall runs
    run(0, 0, 400, 1, t, fin);
    wait_until(fin + 1);
    chk("abort_pulse_len", int'(if0.aborted), 0);
    chk("abort_busy", int'(if0.busy), 0);
    if0.abort = 1'b1;
    tick();
    if0.abort = 1'b0;
    chk("abort_idle_ignored", int'(if0.aborted), 0);
    drain(0, cyc);
    run(0, -1, -1, 0, t, fin);
    wait_until(fin + 2);
    chk("post_abort_perf", int'(if0.perf_cycles), 829);
    drain(0, cyc);
    run(0, -1, -1, 1, t, fin);
    wait_until(fin + 2);
    drain(0, cyc);

    // done/ack handshake, start while busy, abort in DONE, back-to-back start
    if0.done_ack = 1'b0;
    run(0, -1, -1, 1, t, fin);
    wait_until(t + $urandom_range(5, 600));
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    wait_until(fin);
    for (int i = 0; i < 50; i++) begin
      chk("hs_done_hold", int'(if0.done), 1);
      if0.abort = (i == 10);
      tick();
    end
    if0.abort = 1'b0;
    if0.done_ack = 1'b1;
    run(0, -1, -1, 0, t, fin);
    chk("hs_b2b_busy", int'(if0.busy), 1);
    wait_until(fin + 2);
    chk("hs_b2b_perf", int'(if0.perf_cycles), 829);
    drain(0, cyc);

    // three-layer configuration
    run(1, -1, -1, 0, t, fin);
    wait_until(fin + 2);
    chk("cfg3_perf", int'(if1.perf_cycles), 46);
    drain(1, cyc);
    run(1, -1, -1, 1, t, fin);
    wait_until(fin + 2);
    drain(1, cyc);
    al = $urandom_range(0, 2);
    ar = $urandom_range(0, cfg_sz[1][al] - 1);
    run(1, al, ar, 1, t, fin);
    wait_until(fin + 2);
    drain(1, cyc);

    // reset during layer-1 MAC
    run(0, -1, -1, 1, t, fin);
    r_cyc = fin - 10;
    wait_until(r_cyc);
    rst = 1'b1;
    tick();
    #2;
    chk("mrst_busy", int'(if0.busy), 0);
    chk("mrst_perf", int'(if0.perf_cycles), 0);
    chk("mrst_mac_en", int'(if0.mac_en), 0);
    chk("mrst_row", int'(if0.row_idx), 0);
    chk("mrst_layer", int'(if0.layer_idx), 0);
    chk("mrst_done", int'(if0.done), 0);
    rst = 1'b0;
    drain(0, r_cyc);
    repeat (3) tick();
    chk("mrst_stays_idle", int'(if0.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
